// File: rtl/friet_c_stream_out_arbiter_pkg.sv
// Shared definitions for the FRIET-C output stream arbiter.
// State encoding, requester indices and default widths.
package friet_c_stream_out_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

  localparam logic REQ0 = 1'b0;  // ciphertext requester
  localparam logic REQ1 = 1'b1;  // tag requester

  localparam int DIN_WIDTH_DEF      = 128;
  localparam int DIN_SIZE_WIDTH_DEF = 4;

endpackage

// File: rtl/friet_c_stream_slot.sv
// Single-entry output slot: holds one beat (data, size, last, source) until
// the downstream buffer takes it. A load on the same cycle as a drain keeps
// the slot full with the new beat.
module friet_c_stream_slot
  import friet_c_stream_out_arbiter_pkg::*;
#(
  parameter int DIN_WIDTH      = DIN_WIDTH_DEF,
  parameter int DIN_SIZE_WIDTH = DIN_SIZE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [DIN_WIDTH-1:0]      load_data,
  input  logic [DIN_SIZE_WIDTH:0]   load_size,
  input  logic                      load_last,
  input  logic                      load_src,
  input  logic                      dout_ready,
  output logic [DIN_WIDTH-1:0]      dout,
  output logic [DIN_SIZE_WIDTH:0]   dout_size,
  output logic                      dout_last,
  output logic                      dout_valid,
  output logic                      dout_src
);

  // Slot register: load wins over drain; data fields only change on a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_size  <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
      dout_src   <= REQ0;
    end else if (load) begin
      dout       <= load_data;
      dout_size  <= load_size;
      dout_last  <= load_last;
      dout_valid <= 1'b1;
      dout_src   <= load_src;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/friet_c_stream_out_arbiter.sv
// Two-requester packet arbiter in front of the FRIET-C output stream buffer.
// A grant is held for a whole packet; IDLE costs one arbitration bubble.
// Build option FRIET_ARB_FIXED_PRIORITY_EN: requester 0 always wins a tie;
// otherwise ties go round-robin against the last-served pointer.
module friet_c_stream_out_arbiter
  import friet_c_stream_out_arbiter_pkg::*;
#(
  parameter int DIN_WIDTH      = DIN_WIDTH_DEF,
  parameter int DIN_SIZE_WIDTH = DIN_SIZE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIN_WIDTH-1:0]      din0,
  input  logic [DIN_SIZE_WIDTH:0]   din0_size,
  input  logic                      din0_last,
  input  logic                      din0_valid,
  output logic                      din0_ready,
  input  logic [DIN_WIDTH-1:0]      din1,
  input  logic [DIN_SIZE_WIDTH:0]   din1_size,
  input  logic                      din1_last,
  input  logic                      din1_valid,
  output logic                      din1_ready,
  output logic [DIN_WIDTH-1:0]      dout,
  output logic [DIN_SIZE_WIDTH:0]   dout_size,
  output logic                      dout_last,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_src,
  output logic                      busy
);

  arb_state_e state, state_nxt;
  logic       last_srv;
  logic       can_take;
  logic       win1;
  logic       acc0, acc1;

  // Slot can take a beat when empty or when it is draining this cycle.
  assign can_take = !dout_valid || dout_ready;
  assign acc0     = din0_valid && din0_ready;
  assign acc1     = din1_valid && din1_ready;
  assign busy     = (state != IDLE);

  // Arbitration winner, only consulted in IDLE with some request pending.
  always_comb begin
`ifdef FRIET_ARB_FIXED_PRIORITY_EN
    win1 = !din0_valid;
`else
    win1 = din1_valid && (!din0_valid || last_srv == REQ0);
`endif
  end

  // Next state and per-port ready; only the granted port may be ready.
  always_comb begin
    state_nxt  = state;
    din0_ready = 1'b0;
    din1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (din0_valid || din1_valid)
          state_nxt = win1 ? GRANT1 : GRANT0;
      end
      GRANT0: begin
        din0_ready = can_take;
        if (din0_valid && can_take && din0_last) state_nxt = IDLE;
      end
      GRANT1: begin
        din1_ready = can_take;
        if (din1_valid && can_take && din1_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and last-served pointer (updated on a packet's final beat).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_srv <= REQ1;
    end else begin
      state <= state_nxt;
      if (acc0 && din0_last)      last_srv <= REQ0;
      else if (acc1 && din1_last) last_srv <= REQ1;
    end
  end

  friet_c_stream_slot #(
    .DIN_WIDTH      (DIN_WIDTH),
    .DIN_SIZE_WIDTH (DIN_SIZE_WIDTH)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (acc0 || acc1),
    .load_data  (acc1 ? din1 : din0),
    .load_size  (acc1 ? din1_size : din0_size),
    .load_last  (acc1 ? din1_last : din0_last),
    .load_src   (acc1 ? REQ1 : REQ0),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_size  (dout_size),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_src   (dout_src)
  );

endmodule

// File: tb/tb_friet_c_stream_out_arbiter.sv
// Directed self-checking bench for friet_c_stream_out_arbiter.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_friet_c_stream_out_arbiter;

  localparam int W  = 128;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din0, din1, dout;
  logic [SW:0]   din0_size, din1_size, dout_size;
  logic          din0_last, din0_valid, din0_ready;
  logic          din1_last, din1_valid, din1_ready;
  logic          dout_last, dout_valid, dout_ready, dout_src, busy;

  int chk  = 0;
  int fail = 0;

  friet_c_stream_out_arbiter #(.DIN_WIDTH(W), .DIN_SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .din0(din0), .din0_size(din0_size), .din0_last(din0_last),
    .din0_valid(din0_valid), .din0_ready(din0_ready),
    .din1(din1), .din1_size(din1_size), .din1_last(din1_last),
    .din1_valid(din1_valid), .din1_ready(din1_ready),
    .dout(dout), .dout_size(dout_size), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_src(dout_src), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    din0 = '0; din0_size = '0; din0_last = 1'b0; din0_valid = 1'b0;
    din1 = '0; din1_size = '0; din1_last = 1'b0; din1_valid = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset state observed before any clock edge.
  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk++;
    if ({din0_ready, din1_ready, busy, dout_valid, dout_last, dout_src} !== 6'b0) begin
      fail++; $display("FAIL reset_ctrl: got %b exp 000000",
                       {din0_ready, din1_ready, busy, dout_valid, dout_last, dout_src});
    end
    chk++;
    if ({dout, dout_size} !== '0) begin
      fail++; $display("FAIL reset_data: got %h/%h exp 0/0", dout, dout_size);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One 3-beat packet on din0, sizes 16,16,5.
  task automatic test_single();
    do_reset();
    dout_ready = 1'b1;
    din0 = W'(128'h11); din0_size = 5'd16; din0_last = 1'b0; din0_valid = 1'b1;
    #1;
    chk++;
    if ({din0_ready, busy} !== 2'b00) begin
      fail++; $display("FAIL single_idle_bubble: got %b exp 00", {din0_ready, busy});
    end
    step();
    chk++;
    if ({din0_ready, din1_ready, busy, dout_valid} !== 4'b1010) begin
      fail++; $display("FAIL single_grant: got %b exp 1010",
                       {din0_ready, din1_ready, busy, dout_valid});
    end
    step();
    chk++;
    if ({dout_valid, dout_src, dout_last, dout_size, dout} !== {3'b100, 5'd16, W'(128'h11)}) begin
      fail++; $display("FAIL single_beat0: got v%b s%b l%b sz%0d %h exp v1 s0 l0 sz16 11",
                       dout_valid, dout_src, dout_last, dout_size, dout);
    end
    din0 = W'(128'h22);
    step();
    chk++;
    if ({dout_valid, dout_src, dout_last, dout_size, dout} !== {3'b100, 5'd16, W'(128'h22)}) begin
      fail++; $display("FAIL single_beat1: got v%b s%b l%b sz%0d %h exp v1 s0 l0 sz16 22",
                       dout_valid, dout_src, dout_last, dout_size, dout);
    end
    din0 = W'(128'h33); din0_size = 5'd5; din0_last = 1'b1;
    step();
    chk++;
    if ({dout_valid, dout_src, dout_last, dout_size, dout} !== {3'b101, 5'd5, W'(128'h33)}) begin
      fail++; $display("FAIL single_beat2: got v%b s%b l%b sz%0d %h exp v1 s0 l1 sz5 33",
                       dout_valid, dout_src, dout_last, dout_size, dout);
    end
    chk++;
    if (busy !== 1'b0) begin
      fail++; $display("FAIL single_release: got busy=%b exp 0", busy);
    end
    din0_valid = 1'b0; din0_last = 1'b0;
    step();
    chk++;
    if (dout_valid !== 1'b0) begin
      fail++; $display("FAIL single_drain: got %b exp 0", dout_valid);
    end
  endtask

  // Both requesters offer two 2-beat packets each; record output order.
  task automatic test_contention();
    logic [7:0] got_d [8];
    logic       got_s [8];
`ifdef FRIET_ARB_FIXED_PRIORITY_EN
    logic [7:0] exp_d [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83};
`else
    logic [7:0] exp_d [8] = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h02, 8'h03, 8'h82, 8'h83};
`endif
    int  idx0 = 0, idx1 = 0, n_out = 0;
    logic a0, a1, hs;
    do_reset();
    dout_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
      din0_valid = (idx0 < 4); din0 = W'(idx0);       din0_last = (idx0 % 2 == 1); din0_size = 5'd16;
      din1_valid = (idx1 < 4); din1 = W'(128 + idx1); din1_last = (idx1 % 2 == 1); din1_size = 5'd16;
      #1;
      a0 = din0_valid && din0_ready;
      a1 = din1_valid && din1_ready;
      hs = dout_valid && dout_ready;
      if (hs) begin
        got_d[n_out] = dout[7:0];
        got_s[n_out] = dout_src;
        n_out++;
      end
      step();
      if (a0) idx0++;
      if (a1) idx1++;
    end
    clear_inputs();
    chk++;
    if (n_out != 8) begin
      fail++; $display("FAIL contention_timeout: got %0d beats exp 8", n_out);
    end else begin
      for (int i = 0; i < 8; i++) begin
        chk++;
        if ({got_s[i], got_d[i]} !== {exp_d[i][7], exp_d[i]}) begin
          fail++; $display("FAIL contention_beat%0d: got src%b %h exp src%b %h",
                           i, got_s[i], got_d[i], exp_d[i][7], exp_d[i]);
        end
      end
    end
  endtask

  // Slot full with dout_ready low for 4 cycles, then drain at full rate.
  task automatic test_backpressure();
    do_reset();
    din0 = W'(128'hA); din0_size = 5'd16; din0_last = 1'b0; din0_valid = 1'b1;
    step();
    chk++;
    if (din0_ready !== 1'b1) begin
      fail++; $display("FAIL bp_empty_ready: got %b exp 1", din0_ready);
    end
    step();
    din0 = W'(128'hB);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk++;
      if ({din0_ready, dout_valid, dout_size, dout} !== {2'b01, 5'd16, W'(128'hA)}) begin
        fail++; $display("FAIL bp_stall%0d: got rdy%b v%b sz%0d %h exp rdy0 v1 sz16 a",
                         i, din0_ready, dout_valid, dout_size, dout);
      end
      step();
    end
    dout_ready = 1'b1;
    #1;
    chk++;
    if (din0_ready !== 1'b1) begin
      fail++; $display("FAIL bp_release_ready: got %b exp 1", din0_ready);
    end
    step();
    chk++;
    if ({dout_valid, dout} !== {1'b1, W'(128'hB)}) begin
      fail++; $display("FAIL bp_drain_b: got v%b %h exp v1 b", dout_valid, dout);
    end
    din0 = W'(128'hC); din0_last = 1'b1;
    step();
    chk++;
    if ({dout_valid, dout_last, busy, dout} !== {3'b110, W'(128'hC)}) begin
      fail++; $display("FAIL bp_drain_c: got v%b l%b busy%b %h exp v1 l1 busy0 c",
                       dout_valid, dout_last, busy, dout);
    end
    clear_inputs();
  endtask

  // din1 requests mid din0 packet and must wait for din0's last beat.
  task automatic test_packet_lock();
    do_reset();
    dout_ready = 1'b1;
    din0 = W'(128'hA0); din0_size = 5'd16; din0_last = 1'b0; din0_valid = 1'b1;
    step();
    step();
    din1 = W'(128'hD1); din1_size = 5'd7; din1_last = 1'b1; din1_valid = 1'b1;
    for (int i = 1; i < 4; i++) begin
      din0 = W'(128'hA0 + i); din0_last = (i == 3);
      #1;
      chk++;
      if ({din0_ready, din1_ready} !== 2'b10) begin
        fail++; $display("FAIL lock_beat%0d: got rdy0=%b rdy1=%b exp 1 0", i, din0_ready, din1_ready);
      end
      step();
    end
    din0_valid = 1'b0; din0_last = 1'b0;
    #1;
    chk++;
    if ({busy, din1_ready, dout_src, dout_last, dout} !== {4'b0001, W'(128'hA3)}) begin
      fail++; $display("FAIL lock_din0_done: got busy%b rdy1%b src%b l%b %h exp 0 0 0 1 a3",
                       busy, din1_ready, dout_src, dout_last, dout);
    end
    step();
    chk++;
    if ({busy, din1_ready} !== 2'b11) begin
      fail++; $display("FAIL lock_grant1: got busy%b rdy1%b exp 1 1", busy, din1_ready);
    end
    step();
    chk++;
    if ({dout_valid, dout_src, dout_last, dout_size, dout} !== {3'b111, 5'd7, W'(128'hD1)}) begin
      fail++; $display("FAIL lock_din1_beat: got v%b s%b l%b sz%0d %h exp v1 s1 l1 sz7 d1",
                       dout_valid, dout_src, dout_last, dout_size, dout);
    end
    clear_inputs();
  endtask

  // Reset during beat 2 of a 4-beat packet, then a fresh packet.
  task automatic test_reset_mid();
    do_reset();
    dout_ready = 1'b1;
    din0 = W'(128'hE0); din0_size = 5'd16; din0_last = 1'b0; din0_valid = 1'b1;
    step();
    step();
    din0 = W'(128'hE1);
    step();
    din0 = W'(128'hE2);
    rst = 1'b0;
    #1;
    chk++;
    if ({dout_valid, busy, din0_ready, dout_src, dout_last} !== 5'b0) begin
      fail++; $display("FAIL rstmid_ctrl: got %b exp 00000",
                       {dout_valid, busy, din0_ready, dout_src, dout_last});
    end
    chk++;
    if ({dout, dout_size} !== '0) begin
      fail++; $display("FAIL rstmid_data: got %h/%h exp 0/0", dout, dout_size);
    end
    clear_inputs();
    step();
    rst = 1'b1;
    dout_ready = 1'b1;
    din0 = W'(128'hF0); din0_size = 5'd9; din0_last = 1'b0; din0_valid = 1'b1;
    din1 = W'(128'hF8); din1_size = 5'd9; din1_last = 1'b1; din1_valid = 1'b1;
    step();
    chk++;
    if ({busy, din0_ready, din1_ready} !== 3'b110) begin
      fail++; $display("FAIL rstmid_regrant: got busy%b rdy0%b rdy1%b exp 1 1 0",
                       busy, din0_ready, din1_ready);
    end
    step();
    din0 = W'(128'hF1); din0_last = 1'b1;
    step();
    chk++;
    if ({dout_valid, dout_src, dout_last, busy, dout} !== {4'b1010, W'(128'hF1)}) begin
      fail++; $display("FAIL rstmid_fresh: got v%b s%b l%b busy%b %h exp v1 s0 l1 busy0 f1",
                       dout_valid, dout_src, dout_last, busy, dout);
    end
    clear_inputs();
  endtask

  // Zero-size last beat is forwarded untouched and releases the grant.
  task automatic test_size0();
    do_reset();
    dout_ready = 1'b1;
    din1 = W'(128'h5A); din1_size = 5'd0; din1_last = 1'b1; din1_valid = 1'b1;
    step();
    chk++;
    if ({busy, din1_ready, din0_ready} !== 3'b110) begin
      fail++; $display("FAIL size0_grant: got busy%b rdy1%b rdy0%b exp 1 1 0",
                       busy, din1_ready, din0_ready);
    end
    step();
    din1_valid = 1'b0;
    chk++;
    if ({dout_valid, dout_src, dout_last, busy, dout_size, dout} !== {4'b1110, 5'd0, W'(128'h5A)}) begin
      fail++; $display("FAIL size0_out: got v%b s%b l%b busy%b sz%0d %h exp v1 s1 l1 busy0 sz0 5a",
                       dout_valid, dout_src, dout_last, busy, dout_size, dout);
    end
    step();
    chk++;
    if ({dout_valid, busy} !== 2'b00) begin
      fail++; $display("FAIL size0_drain: got v%b busy%b exp 0 0", dout_valid, busy);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_packet_lock();
    test_reset_mid();
    test_size0();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
    $finish;
  end

endmodule

// File: doc/friet_c_stream_out_arbiter.md
FRIET_C_STREAM_OUT_ARBITER -- requirements
Module: friet_c_stream_out_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DIN_WIDTH, 128, beat data width in bits.
- DIN_SIZE_WIDTH, 4, byte-count width minus one.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- rst, in, 1, asynchronous, active-low reset.
- din0 / din0_size / din0_last / din0_valid, in, DIN_WIDTH / DIN_SIZE_WIDTH+1 / 1 / 1, requester 0 (ciphertext) stream.
- din0_ready, out, 1, requester 0 beat accepted.
- din1 / din1_size / din1_last / din1_valid, in, same widths, requester 1 (tag) stream.
- din1_ready, out, 1, requester 1 beat accepted.
- dout / dout_size / dout_last, out, DIN_WIDTH / DIN_SIZE_WIDTH+1 / 1, to output stream buffer.
- dout_valid, out, 1, output slot full.
- dout_ready, in, 1, downstream buffer accepts.
- dout_src, out, 1, requester index of the beat in the slot.
- busy, out, 1, high while a packet is granted.

Function
REQ-003 A beat SHALL transfer only on valid&ready of the same port, in the same cycle.
REQ-004 FSM states SHALL be IDLE, GRANT0, GRANT1.
REQ-005 In IDLE, din0_ready and din1_ready SHALL be 0.
REQ-006 In IDLE with any dinX_valid, the FSM SHALL move to the arbitration winner's GRANT state next cycle; this is a one-cycle arbitration bubble.
REQ-007 In IDLE with no valid, the FSM SHALL stay in IDLE.
REQ-008 In GRANTk, dink_ready SHALL equal (slot empty) OR (dout_valid AND dout_ready); the other port's ready SHALL be 0.
REQ-009 In GRANTk, an accepted beat with dink_last=1 SHALL return the FSM to IDLE and set the last-served pointer to k.
REQ-010 A grant SHALL be held for the whole packet, from the first beat through the last-flagged beat, regardless of the other requester.
REQ-011 The output slot SHALL be a single register:
- load din/size/last and the source index on an accepted beat;
- clear dout_valid on a dout handshake with no simultaneous load;
- on a simultaneous load and drain, dout_valid SHALL stay 1 with the new contents.
REQ-012 Latency SHALL be one cycle from input acceptance to dout_valid.
REQ-013 Full throughput (one beat per cycle) SHALL be sustained inside a packet while dout_ready=1.
REQ-014 dinX_size SHALL pass through unmodified; size 0 SHALL be forwarded as is (no check).
REQ-015 busy SHALL be 1 in GRANT0/GRANT1 and 0 in IDLE.
REQ-016 Data fields in the slot SHALL be stable while dout_valid=1 and dout_ready=0.

Reset
REQ-017 rst=0 SHALL immediately force the following, independent of clk:
- state IDLE, dout_valid=0, dout_last=0, dout_size=0, dout=0, dout_src=0;
- last-served pointer = 1 (requester 0 wins first), busy=0, both readies 0.
REQ-018 Reset asserted mid-packet SHALL discard the slot contents and the packet; after release, arbitration restarts from IDLE.

Configuration
REQ-019 Macro FRIET_ARB_FIXED_PRIORITY_EN:
- defined: requester 0 SHALL always win in IDLE when both are valid;
- undefined: round-robin, where the requester not equal to the last-served pointer wins when both are valid;
- in both modes, a single valid requester always wins.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state encoding (IDLE=2'b00, GRANT0=2'b01, GRANT1=2'b10);
- the requester index constants;
- DIN_WIDTH/DIN_SIZE_WIDTH defaults.
REQ-021 The output slot register SHALL be a sub-module, friet_c_stream_slot; the FSM and arbitration SHALL stay in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single packet: din0 sends 3 beats (sizes 16,16,5, last on 3rd), dout_ready=1 -> dout shows 3 beats on consecutive cycles after a 1-cycle bubble, dout_src=0, dout_last only on size-5 beat, then busy=0.
- Contention, round-robin build: both valid with 2-beat packets after reset -> order 0,1,0,1; with FRIET_ARB_FIXED_PRIORITY_EN and din0 always pending -> din1 never granted.
- Backpressure: dout_ready=0 for 4 cycles with slot full -> dink_ready=0, dout fields stable, then drain at 1 beat/cycle.
- Packet lock: din1 asserts valid mid din0 packet -> din1_ready stays 0 until din0 last beat accepted.
- Reset mid-packet: rst low during beat 2 of 4 -> dout_valid=0 immediately, state IDLE; after release, a fresh packet completes normally.
- Size 0 beat with last=1 -> forwarded with dout_size=0, dout_last=1, grant released.
